// File: rtl/freq_sweep_tracker.sv
// freq_sweep_tracker
//   Sweeps the drive frequency over a configured window, settles at each point, averages
//   2^AVG_LOG2 folded ADC magnitudes and tracks the frequency with the largest mean.
//   An optional fine pass re-sweeps +/- one coarse step around the coarse best point.
// Ports:
//   clk, nrst                 clock, asynchronous active-low reset
//   swiptAlive                link alive; low aborts to idle on the next edge
//   start                     one-cycle sweep request (accepted only when idle/done)
//   cfg_f_start/cfg_f_stop    sweep window (inclusive)
//   cfg_step/cfg_fine_step    coarse/fine step (fine_step 0 skips the fine pass)
//   cfg_settle                settle cycles per point (state lasts cfg_settle+1 cycles)
//   adc_valid, adc            offset-binary ADC sample stream
//   newFreq                   commanded drive frequency
//   bestFreq, bestMag         best point so far and its mean magnitude
//   busy, done, err           status levels
module freq_sweep_tracker #(
    parameter int unsigned FREQ_W   = 20,
    parameter int unsigned ADC_W    = 12,
    parameter int unsigned SETTLE_W = 24,
    parameter int unsigned AVG_LOG2 = 3,
    parameter bit          FINE_EN  = 1'b1
) (
    input  logic                clk,
    input  logic                nrst,
    input  logic                swiptAlive,
    input  logic                start,
    input  logic [FREQ_W-1:0]   cfg_f_start,
    input  logic [FREQ_W-1:0]   cfg_f_stop,
    input  logic [FREQ_W-1:0]   cfg_step,
    input  logic [FREQ_W-1:0]   cfg_fine_step,
    input  logic [SETTLE_W-1:0] cfg_settle,
    input  logic                adc_valid,
    input  logic [ADC_W-1:0]    adc,
    output logic [FREQ_W-1:0]   newFreq,
    output logic [FREQ_W-1:0]   bestFreq,
    output logic [ADC_W-1:0]    bestMag,
    output logic                busy,
    output logic                done,
    output logic                err
);
    localparam int unsigned ACC_W = ADC_W + AVG_LOG2;
    localparam int unsigned CNT_W = AVG_LOG2 + 1;
    localparam logic [CNT_W-1:0] LAST_SAMP = CNT_W'((2 ** AVG_LOG2) - 1);

    typedef enum logic [2:0] {
        StIdle, StSettle, StAcq, StEval, StStep, StFineSetup, StDone
    } state_e;

    state_e              state_q, state_d;
    logic [SETTLE_W-1:0] settle_cnt_q, settle_cnt_d, settle_q, settle_d;
    logic [ACC_W-1:0]    acc_q, acc_d;
    logic [CNT_W-1:0]    samp_cnt_q, samp_cnt_d;
    logic [FREQ_W-1:0]   new_freq_q, new_freq_d, best_freq_q, best_freq_d;
    logic [ADC_W-1:0]    best_mag_q, best_mag_d;
    logic                busy_q, busy_d, done_q, done_d, err_q, err_d;
    logic [FREQ_W-1:0]   f_start_q, f_start_d, f_stop_q, f_stop_d;
    logic [FREQ_W-1:0]   coarse_step_q, coarse_step_d, fine_step_q, fine_step_d;
    logic [FREQ_W-1:0]   step_q, step_d, pass_stop_q, pass_stop_d;
    logic                fine_pass_q, fine_pass_d;

    logic [ADC_W-1:0]  mag, mean;
    logic [FREQ_W:0]   nxt_ext, hi_ext;
    logic [FREQ_W-1:0] lo_sub, lo, hi;
    logic              cfg_bad;

    always_comb begin
        // Fold offset-binary samples around mid-scale.
        mag     = adc[ADC_W-1] ? ~adc : adc;
        mean    = ADC_W'(acc_q >> AVG_LOG2);
        // One extra bit so a step past the top of the frequency range cannot wrap.
        nxt_ext = {1'b0, new_freq_q} + {1'b0, step_q};
        lo_sub  = (best_freq_q > coarse_step_q) ? (best_freq_q - coarse_step_q) : '0;
        lo      = (lo_sub < f_start_q) ? f_start_q : lo_sub;
        hi_ext  = {1'b0, best_freq_q} + {1'b0, coarse_step_q};
        hi      = (hi_ext > {1'b0, f_stop_q}) ? f_stop_q : hi_ext[FREQ_W-1:0];
        cfg_bad = (cfg_step == '0) || (cfg_f_start > cfg_f_stop);
    end

    always_comb begin
        state_d       = state_q;
        settle_cnt_d  = settle_cnt_q;
        settle_d      = settle_q;
        acc_d         = acc_q;
        samp_cnt_d    = samp_cnt_q;
        new_freq_d    = new_freq_q;
        best_freq_d   = best_freq_q;
        best_mag_d    = best_mag_q;
        busy_d        = busy_q;
        done_d        = done_q;
        err_d         = err_q;
        f_start_d     = f_start_q;
        f_stop_d      = f_stop_q;
        coarse_step_d = coarse_step_q;
        fine_step_d   = fine_step_q;
        step_d        = step_q;
        pass_stop_d   = pass_stop_q;
        fine_pass_d   = fine_pass_q;

        if (!swiptAlive) begin
            state_d    = StIdle;
            busy_d     = 1'b0;
            done_d     = 1'b0;
            acc_d      = '0;
            samp_cnt_d = '0;
        end else begin
            unique case (state_q)
                StIdle, StDone: begin
                    // Park the oscillator on the winner, but not after a rejected config.
                    if (state_q == StDone && !err_q) new_freq_d = best_freq_q;
                    if (start) begin
                        if (cfg_bad) begin
                            new_freq_d = new_freq_q;
                            err_d      = 1'b1;
                            done_d     = 1'b1;
                            busy_d     = 1'b0;
                            state_d    = StDone;
                        end else begin
                            f_start_d     = cfg_f_start;
                            f_stop_d      = cfg_f_stop;
                            coarse_step_d = cfg_step;
                            fine_step_d   = cfg_fine_step;
                            settle_d      = cfg_settle;
                            step_d        = cfg_step;
                            pass_stop_d   = cfg_f_stop;
                            fine_pass_d   = 1'b0;
                            best_freq_d   = cfg_f_start;
                            best_mag_d    = '0;
                            new_freq_d    = cfg_f_start;
                            settle_cnt_d  = cfg_settle;
                            acc_d         = '0;
                            samp_cnt_d    = '0;
                            done_d        = 1'b0;
                            err_d         = 1'b0;
                            busy_d        = 1'b1;
                            state_d       = StSettle;
                        end
                    end
                end
                StSettle: begin
                    if (settle_cnt_q == '0) state_d = StAcq;
                    else settle_cnt_d = settle_cnt_q - 1'b1;
                end
                StAcq: begin
                    if (adc_valid) begin
                        acc_d = acc_q + ACC_W'(mag);
                        if (samp_cnt_q == LAST_SAMP) begin
                            samp_cnt_d = '0;
                            state_d    = StEval;
                        end else begin
                            samp_cnt_d = samp_cnt_q + 1'b1;
                        end
                    end
                end
                StEval: begin
                    // Strict compare: the first point reaching a maximum keeps it.
                    if (mean > best_mag_q) begin
                        best_mag_d  = mean;
                        best_freq_d = new_freq_q;
                    end
                    acc_d   = '0;
                    state_d = StStep;
                end
                StStep: begin
                    if (nxt_ext <= {1'b0, pass_stop_q}) begin
                        new_freq_d   = nxt_ext[FREQ_W-1:0];
                        settle_cnt_d = settle_q;
                        state_d      = StSettle;
                    end else if (FINE_EN && !fine_pass_q && fine_step_q != '0) begin
                        state_d = StFineSetup;
                    end else begin
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        state_d = StDone;
                    end
                end
                StFineSetup: begin
                    step_d       = fine_step_q;
                    pass_stop_d  = hi;
                    new_freq_d   = lo;
                    fine_pass_d  = 1'b1;
                    settle_cnt_d = settle_q;
                    state_d      = StSettle;
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q       <= StIdle;
            settle_cnt_q  <= '0;
            settle_q      <= '0;
            acc_q         <= '0;
            samp_cnt_q    <= '0;
            new_freq_q    <= '0;
            best_freq_q   <= '0;
            best_mag_q    <= '0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            err_q         <= 1'b0;
            f_start_q     <= '0;
            f_stop_q      <= '0;
            coarse_step_q <= '0;
            fine_step_q   <= '0;
            step_q        <= '0;
            pass_stop_q   <= '0;
            fine_pass_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            settle_cnt_q  <= settle_cnt_d;
            settle_q      <= settle_d;
            acc_q         <= acc_d;
            samp_cnt_q    <= samp_cnt_d;
            new_freq_q    <= new_freq_d;
            best_freq_q   <= best_freq_d;
            best_mag_q    <= best_mag_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            err_q         <= err_d;
            f_start_q     <= f_start_d;
            f_stop_q      <= f_stop_d;
            coarse_step_q <= coarse_step_d;
            fine_step_q   <= fine_step_d;
            step_q        <= step_d;
            pass_stop_q   <= pass_stop_d;
            fine_pass_q   <= fine_pass_d;
        end
    end

    assign newFreq  = new_freq_q;
    assign bestFreq = best_freq_q;
    assign bestMag  = best_mag_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign err      = err_q;
endmodule

// File: tb/tb_freq_sweep_tracker.sv
// Directed bench for freq_sweep_tracker (AVG_LOG2=2, fine pass present).
// The ADC input is a per-frequency profile: a base level with up to two peaks.
module tb_freq_sweep_tracker;
    localparam int FW = 20;
    localparam int AW = 12;
    localparam int SW = 24;

    logic          clk = 1'b0;
    logic          nrst = 1'b1;
    logic          swiptAlive = 1'b1;
    logic          start = 1'b0;
    logic [FW-1:0] cfg_f_start = '0, cfg_f_stop = '0, cfg_step = '0, cfg_fine_step = '0;
    logic [SW-1:0] cfg_settle = '0;
    logic          adc_valid = 1'b1;
    logic [AW-1:0] adc;
    logic [FW-1:0] newFreq, bestFreq;
    logic [AW-1:0] bestMag;
    logic          busy, done, err;

    freq_sweep_tracker #(
        .FREQ_W(FW), .ADC_W(AW), .SETTLE_W(SW), .AVG_LOG2(2), .FINE_EN(1'b1)
    ) dut (
        .clk(clk), .nrst(nrst), .swiptAlive(swiptAlive), .start(start),
        .cfg_f_start(cfg_f_start), .cfg_f_stop(cfg_f_stop), .cfg_step(cfg_step),
        .cfg_fine_step(cfg_fine_step), .cfg_settle(cfg_settle),
        .adc_valid(adc_valid), .adc(adc),
        .newFreq(newFreq), .bestFreq(bestFreq), .bestMag(bestMag),
        .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    int tests_run = 0;
    int tests_failed = 0;

    logic [FW-1:0] pk_f0 = 20'd1, pk_f1 = 20'd1;
    logic [AW-1:0] pk_v0 = 12'h100, pk_v1 = 12'h100;

    always_comb begin
        adc = 12'h100;
        if (newFreq == pk_f0) adc = pk_v0;
        else if (newFreq == pk_f1) adc = pk_v1;
    end

    logic [FW-1:0] pts [32];
    int            npts, busy_cyc;
    bit            fin;

    task automatic set_profile(input logic [FW-1:0] f0, input logic [AW-1:0] v0,
                               input logic [FW-1:0] f1, input logic [AW-1:0] v1);
        pk_f0 = f0; pk_v0 = v0; pk_f1 = f1; pk_v1 = v1;
    endtask

    task automatic pulse_start(input logic [FW-1:0] fs, input logic [FW-1:0] fe,
                               input logic [FW-1:0] st, input logic [FW-1:0] fst,
                               input logic [SW-1:0] se);
        @(negedge clk);
        cfg_f_start = fs; cfg_f_stop = fe; cfg_step = st; cfg_fine_step = fst; cfg_settle = se;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Waits (bounded) for done, logging commanded points and busy cycles.
    task automatic wait_done();
        npts = 0; busy_cyc = 0; fin = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if (done) begin
                fin = 1'b1;
                break;
            end
            if (busy) begin
                busy_cyc++;
                if (npts < 32 && (npts == 0 || pts[npts-1] !== newFreq)) begin
                    pts[npts] = newFreq;
                    npts++;
                end
            end
            @(negedge clk);
        end
    endtask

    // Starts a sweep, then scrambles the config inputs to show they were latched.
    task automatic run_sweep(input logic [FW-1:0] fs, input logic [FW-1:0] fe,
                             input logic [FW-1:0] st, input logic [FW-1:0] fst,
                             input logic [SW-1:0] se);
        pulse_start(fs, fe, st, fst, se);
        cfg_step = '0; cfg_f_stop = '0; cfg_fine_step = 20'd3; cfg_settle = 24'd99;
        wait_done();
    endtask

    task automatic test_reset();
        #1 nrst = 1'b0;
        #10;
        tests_run++;
        if ({newFreq, bestFreq, bestMag, busy, done, err} !== '0) begin
            tests_failed++;
            $display("FAIL reset_outputs: got nf=%0h bf=%0h bm=%0h b/d/e=%b%b%b, want all 0",
                     newFreq, bestFreq, bestMag, busy, done, err);
        end
        @(negedge clk);
        nrst = 1'b1;
    endtask

    task automatic test_coarse();
        set_profile(20'd35100, 12'h300, 20'd1, 12'h100);
        run_sweep(20'd35000, 20'd35200, 20'd50, 20'd0, 24'd4);
        tests_run++;
        if (!fin) begin tests_failed++; $display("FAIL coarse_timeout: done never seen"); end
        tests_run++;
        if (busy_cyc != 55) begin
            tests_failed++; $display("FAIL coarse_busy_cycles: got %0d, want 55", busy_cyc);
        end
        tests_run++;
        if (npts != 5 || pts[0] !== 20'd35000 || pts[4] !== 20'd35200) begin
            tests_failed++;
            $display("FAIL coarse_points: got n=%0d first=%0d last=%0d, want 5/35000/35200",
                     npts, pts[0], pts[4]);
        end
        tests_run++;
        if (bestFreq !== 20'd35100 || bestMag !== 12'h300) begin
            tests_failed++;
            $display("FAIL coarse_best: got %0d/%0h, want 35100/300", bestFreq, bestMag);
        end
        tests_run++;
        if ({busy, done, err} !== 3'b010) begin
            tests_failed++; $display("FAIL coarse_flags: got b/d/e=%b%b%b, want 010", busy, done, err);
        end
        @(negedge clk);
        tests_run++;
        if (newFreq !== 20'd35100) begin
            tests_failed++; $display("FAIL coarse_park: got newFreq=%0d, want 35100", newFreq);
        end
    endtask

    task automatic test_fold_tie();
        set_profile(20'd35050, 12'hCFF, 20'd35150, 12'h300);
        run_sweep(20'd35000, 20'd35200, 20'd50, 20'd0, 24'd4);
        tests_run++;
        if (!fin || bestFreq !== 20'd35050 || bestMag !== 12'h300) begin
            tests_failed++;
            $display("FAIL fold_tie_best: got fin=%0d %0d/%0h, want 1 35050/300",
                     fin, bestFreq, bestMag);
        end
        @(negedge clk);
        tests_run++;
        if (newFreq !== 20'd35050) begin
            tests_failed++; $display("FAIL fold_tie_park: got newFreq=%0d, want 35050", newFreq);
        end
    endtask

    task automatic test_invalid();
        pulse_start(20'd100, 20'd200, 20'd0, 20'd0, 24'd1);
        tests_run++;
        if ({err, done, busy} !== 3'b110 || newFreq !== 20'd35050) begin
            tests_failed++;
            $display("FAIL invalid_step0: got e/d/b=%b%b%b nf=%0d, want 110 35050",
                     err, done, busy, newFreq);
        end
        @(negedge clk);
        tests_run++;
        if (newFreq !== 20'd35050 || err !== 1'b1) begin
            tests_failed++;
            $display("FAIL invalid_hold: got nf=%0d err=%b, want 35050 1", newFreq, err);
        end
        pulse_start(20'd300, 20'd200, 20'd10, 20'd0, 24'd1);
        tests_run++;
        if ({err, done, busy} !== 3'b110 || newFreq !== 20'd35050) begin
            tests_failed++;
            $display("FAIL invalid_order: got e/d/b=%b%b%b nf=%0d, want 110 35050",
                     err, done, busy, newFreq);
        end
    endtask

    task automatic test_fine();
        set_profile(20'd35100, 12'h200, 20'd35120, 12'h300);
        run_sweep(20'd35000, 20'd35200, 20'd50, 20'd10, 24'd4);
        tests_run++;
        if (!fin || busy_cyc != 177) begin
            tests_failed++;
            $display("FAIL fine_busy_cycles: got fin=%0d %0d, want 1 177", fin, busy_cyc);
        end
        tests_run++;
        if (npts != 16 || pts[5] !== 20'd35050 || pts[15] !== 20'd35150) begin
            tests_failed++;
            $display("FAIL fine_window: got n=%0d lo=%0d hi=%0d, want 16/35050/35150",
                     npts, pts[5], pts[15]);
        end
        tests_run++;
        if (bestFreq !== 20'd35120 || bestMag !== 12'h300 || err !== 1'b0) begin
            tests_failed++;
            $display("FAIL fine_best: got %0d/%0h err=%b, want 35120/300 0", bestFreq, bestMag, err);
        end
        @(negedge clk);
        tests_run++;
        if (newFreq !== 20'd35120) begin
            tests_failed++; $display("FAIL fine_park: got newFreq=%0d, want 35120", newFreq);
        end
    endtask

    task automatic test_clamp();
        set_profile(20'hFFFE0, 12'h400, 20'd1, 12'h100);
        run_sweep(20'hFFFC0, 20'hFFFFF, 20'h20, 20'd0, 24'd4);
        tests_run++;
        if (!fin || busy_cyc != 22 || npts != 2 || pts[1] !== 20'hFFFE0) begin
            tests_failed++;
            $display("FAIL clamp_coarse: got fin=%0d cyc=%0d n=%0d last=%0h, want 1 22 2 FFFE0",
                     fin, busy_cyc, npts, pts[1]);
        end
        tests_run++;
        if (bestFreq !== 20'hFFFE0 || bestMag !== 12'h400) begin
            tests_failed++;
            $display("FAIL clamp_best: got %0h/%0h, want FFFE0/400", bestFreq, bestMag);
        end
        run_sweep(20'hFFFC0, 20'hFFFFF, 20'h20, 20'h10, 24'd4);
        tests_run++;
        if (!fin || busy_cyc != 67 || npts != 6 || pts[2] !== 20'hFFFC0 || pts[5] !== 20'hFFFF0)
        begin
            tests_failed++;
            $display("FAIL clamp_fine: got fin=%0d cyc=%0d n=%0d lo=%0h hi=%0h, want 1 67 6 FFFC0 FFFF0",
                     fin, busy_cyc, npts, pts[2], pts[5]);
        end
        set_profile(20'h10, 12'h200, 20'd1, 12'h100);
        run_sweep(20'h10, 20'h30, 20'h20, 20'h10, 24'd0);
        tests_run++;
        if (!fin || busy_cyc != 36 || npts != 5 || pts[2] !== 20'h10 || bestFreq !== 20'h10) begin
            tests_failed++;
            $display("FAIL clamp_low: got fin=%0d cyc=%0d n=%0d lo=%0h bf=%0h, want 1 36 5 10 10",
                     fin, busy_cyc, npts, pts[2], bestFreq);
        end
    endtask

    task automatic test_abort();
        set_profile(20'd35100, 12'h300, 20'd1, 12'h100);
        pulse_start(20'd35000, 20'd35200, 20'd50, 20'd0, 24'd4);
        repeat (6) @(negedge clk);
        swiptAlive = 1'b0;
        @(negedge clk);
        tests_run++;
        if ({busy, done} !== 2'b00 || newFreq !== 20'd35000 || bestFreq !== 20'd35000 ||
            bestMag !== 12'h0) begin
            tests_failed++;
            $display("FAIL abort_state: got b/d=%b%b nf=%0d bf=%0d bm=%0h, want 00 35000 35000 0",
                     busy, done, newFreq, bestFreq, bestMag);
        end
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        tests_run++;
        if (busy !== 1'b0) begin
            tests_failed++; $display("FAIL abort_priority: got busy=%b, want 0", busy);
        end
        swiptAlive = 1'b1;
        run_sweep(20'd35000, 20'd35200, 20'd50, 20'd0, 24'd4);
        tests_run++;
        if (!fin || busy_cyc != 55 || bestFreq !== 20'd35100 || bestMag !== 12'h300) begin
            tests_failed++;
            $display("FAIL abort_rerun: got fin=%0d cyc=%0d %0d/%0h, want 1 55 35100/300",
                     fin, busy_cyc, bestFreq, bestMag);
        end
    endtask

    task automatic test_back_to_back();
        set_profile(20'd35100, 12'h300, 20'd1, 12'h100);
        pulse_start(20'd35000, 20'd35200, 20'd50, 20'd0, 24'd4);
        repeat (20) @(negedge clk);
        // Requests while busy must be ignored, valid or not.
        pulse_start(20'd0, 20'd10, 20'd0, 20'd0, 24'd0);
        pulse_start(20'd1000, 20'd2000, 20'd500, 20'd0, 24'd0);
        wait_done();
        tests_run++;
        if (!fin || err !== 1'b0 || bestFreq !== 20'd35100 || bestMag !== 12'h300) begin
            tests_failed++;
            $display("FAIL busy_start_ignored: got fin=%0d err=%b %0d/%0h, want 1 0 35100/300",
                     fin, err, bestFreq, bestMag);
        end
        set_profile(20'd35050, 12'hCFF, 20'd35150, 12'h300);
        run_sweep(20'd35000, 20'd35200, 20'd50, 20'd0, 24'd4);
        tests_run++;
        if (!fin || busy_cyc != 55 || bestFreq !== 20'd35050) begin
            tests_failed++;
            $display("FAIL start_from_done: got fin=%0d cyc=%0d bf=%0d, want 1 55 35050",
                     fin, busy_cyc, bestFreq);
        end
    endtask

    task automatic test_async_reset();
        pulse_start(20'd35000, 20'd35200, 20'd50, 20'd0, 24'd4);
        @(negedge clk);
        #2 nrst = 1'b0;
        #1;
        tests_run++;
        if ({newFreq, bestFreq, bestMag, busy, done, err} !== '0) begin
            tests_failed++;
            $display("FAIL async_reset: got nf=%0h bf=%0h bm=%0h b/d/e=%b%b%b, want all 0",
                     newFreq, bestFreq, bestMag, busy, done, err);
        end
        @(negedge clk);
        nrst = 1'b1;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_coarse();
        test_fold_tie();
        test_invalid();
        test_fine();
        test_clamp();
        test_abort();
        test_back_to_back();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule

// File: doc/freq_sweep_tracker.md
Name: freq_sweep_tracker

Overview:
Parametrised successor to the SWIPT frequency-search block. On a start request it sweeps the drive frequency over a configurable window and waits a programmable settle time at each point. At each point it averages 2^AVG_LOG2 folded ADC magnitudes and records the frequency with the largest mean. An optional second, fine pass sweeps around the coarse best point. It sits between the SWIPT supervisor (swiptAlive, start) and the drive oscillator (newFreq), and reports bestFreq and bestMag when finished.

Parameters:
FREQ_W, 20, frequency word width in Hz
ADC_W, 12, ADC sample width (unsigned, offset-binary)
SETTLE_W, 24, settle counter width
AVG_LOG2, 3, log2 of the number of samples averaged per point
FINE_EN, 1, 1 = fine pass hardware present; 0 = coarse pass only

Ports:
clk  in  1  system clock
nrst  in  1  asynchronous active-low reset
swiptAlive  in  1  link alive; low = synchronous abort to IDLE
start  in  1  one-cycle sweep request, sampled in IDLE/DONE only
cfg_f_start  in  FREQ_W  first frequency of the sweep
cfg_f_stop  in  FREQ_W  last allowed frequency of the sweep
cfg_step  in  FREQ_W  coarse step
cfg_fine_step  in  FREQ_W  fine step; 0 = skip fine pass
cfg_settle  in  SETTLE_W  settle cycles per point
adc_valid  in  1  ADC sample strobe
adc  in  ADC_W  ADC sample
newFreq  out  FREQ_W  frequency currently commanded
bestFreq  out  FREQ_W  frequency with the highest mean magnitude so far
bestMag  out  ADC_W  mean magnitude at bestFreq
busy  out  1  sweep in progress
done  out  1  level; set at completion, cleared by next accepted start or abort
err  out  1  level; config invalid, cleared by next accepted start

Behaviour:
- Async reset: all outputs 0, state IDLE, counters and accumulator 0.
- Config latched on the accepted start cycle. It is ignored afterwards until the next start.
- Invalid config: cfg_step==0 or cfg_f_start>cfg_f_stop. Next cycle err=1, done=1, busy=0, newFreq unchanged, no sweep. Then DONE.
- Valid start: bestFreq<=cfg_f_start, bestMag<=0, done<=0, err<=0, busy<=1. newFreq<=cfg_f_start, enter SETTLE.
- States: IDLE, SETTLE, ACQ, EVAL, STEP, FINE_SETUP, DONE.
- SETTLE: counter loaded with cfg_settle on entry and decremented each cycle. The state exits to ACQ on the cycle the counter is 0, so SETTLE lasts cfg_settle+1 cycles. adc_valid is ignored in SETTLE.
- ACQ: on each adc_valid, mag = adc[MSB] ? ~adc : adc (ADC_W bits). Accumulate into an ADC_W+AVG_LOG2 accumulator, which cannot overflow. After 2^AVG_LOG2 samples go to EVAL. ACQ waits indefinitely for samples.
- EVAL (1 cycle): mean = acc >> AVG_LOG2. If mean > bestMag (strict; first maximum wins), then bestMag<=mean and bestFreq<=newFreq. Clear the accumulator.
- STEP (1 cycle): nxt = newFreq + step, computed at FREQ_W+1 bits.
  - If nxt <= pass_stop, newFreq<=nxt and go to SETTLE.
  - Otherwise (including carry-out) the pass ends. pass_stop itself is measured only if hit exactly.
- After the coarse pass:
  - If FINE_EN and cfg_fine_step!=0, go to FINE_SETUP.
  - Otherwise go to DONE.
- FINE_SETUP (1 cycle): lo = max(bestFreq - cfg_step, cfg_f_start), saturating at 0. hi = min(bestFreq + cfg_step, cfg_f_stop). Step = cfg_fine_step, pass_stop = hi, newFreq<=lo, go to SETTLE. The best values carry over from the coarse pass. A fine pass ending goes to DONE.
- DONE: busy=0, done=1, newFreq<=bestFreq (1 cycle after entry). newFreq, bestFreq and bestMag hold. start is accepted here as from IDLE.
- swiptAlive low in any state: next cycle state IDLE, busy=0, done=0, accumulator cleared. newFreq, bestFreq and bestMag hold. Low swiptAlive has priority over a simultaneous start.
- start while busy: ignored.
- adc_valid in the same cycle as a state exit from ACQ: counted only if the count is below 2^AVG_LOG2. Excess samples are dropped.

Test Plan:
- Coarse only, AVG_LOG2=2: start=35000, stop=35200, step=50, settle=4, fine_step=0. ADC constant 0x100 except 0x300 at 35100 -> points 35000..35200 visited, each SETTLE 5 cycles. bestFreq=35100, bestMag=0x300, done=1, newFreq=35100 at end.
- Folding and tie: adc=0xCFF at 35050 (mag 0x300) and adc=0x300 at 35150 -> bestFreq=35050 (first max wins).
- Fine pass: same setup, fine_step=10, peak at 35120 -> fine window 35050..35150 in steps of 10. bestFreq=35120.
- Window clamp and overflow: start=0xFFFC0, stop=0xFFFFF, step=0x20 -> 0xFFFC0, 0xFFFE0 measured, no wrap to 0. Fine lo/hi clamped to start/stop.
- Invalid config: step=0 or start>stop -> err=1, done=1, busy=0 next cycle, newFreq unchanged.
- Abort and reset: drop swiptAlive mid-ACQ -> IDLE next cycle, busy=0, done=0. A new start reruns cleanly. Assert nrst mid-SETTLE -> all outputs 0 immediately, with no clock edge.
